// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch front end and its neighbours.
package riscv_pkg;

    // Architectural data / PC width.
    localparam int XLEN = 32;

    // Canonical NOP (addi x0, x0, 0); shown on the output stage after reset.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch sequencer states. HALT is terminal until reset.
    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    // A redirect target is usable only if it is word aligned.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage : riscv_pkg

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM
// combinationally and captures the returned word into a one-entry
// valid/ready output stage. Execute can redirect the PC; a misaligned
// redirect target stops fetching until reset.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int               XLEN_P   = XLEN,
    parameter int               ADDR_W   = 12,
    parameter logic [XLEN_P-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_vld,
    input  logic [XLEN_P-1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [XLEN_P-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN_P-1:0] out_instr,
    output logic [XLEN_P-1:0] out_pc,
    output logic              fetch_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_t      state_reg,     state_next;
    logic [XLEN_P-1:0] pc_reg,        pc_next;
    logic              out_valid_reg, out_valid_next;
    logic [XLEN_P-1:0] out_instr_reg, out_instr_next;
    logic [XLEN_P-1:0] out_pc_reg,    out_pc_next;
    logic              fetch_err_reg, fetch_err_next;

    // Decode strobes, exposed as named nets so the priority order is visible.
    logic running;
    logic redirect_bad;   // misaligned redirect: halt
    logic redirect_ok;    // aligned redirect: flush and retarget
    logic slot_free;      // output stage empty or draining this cycle
    logic load;           // capture rom_data into the output stage
    logic drain;          // consumer takes the last word and no refill

    // ------------------------------------------------------------------
    // ROM addressing and next-state decode.
    // Priority: bad redirect > good redirect > load > drain > hold.
    // A redirect always kills the word in the output stage, even if the
    // consumer is accepting it this same cycle; decode treats it as a kill.
    // ------------------------------------------------------------------
    always_comb begin
        // Word address: drop the byte offset, ignore PC bits above the ROM,
        // so fetches wrap around the ROM image.
        rom_addr = pc_reg[ADDR_W+1:2];

        running      = (state_reg == FETCH_RUN);
        redirect_bad = running && redirect_vld && !is_word_aligned(redirect_pc[1:0]);
        redirect_ok  = running && redirect_vld &&  is_word_aligned(redirect_pc[1:0]);
        slot_free    = !out_valid_reg || out_ready;
        load         = running && !redirect_vld && fetch_en && slot_free;
        drain        = running && !redirect_vld && !fetch_en && out_valid_reg && out_ready;

        // Default: every register holds (covers stall and HALT).
        state_next     = state_reg;
        pc_next        = pc_reg;
        out_valid_next = out_valid_reg;
        out_instr_next = out_instr_reg;
        out_pc_next    = out_pc_reg;
        fetch_err_next = fetch_err_reg;

        if (redirect_bad) begin
            // PC is left where it was so the failing context is preserved.
            out_valid_next = 1'b0;
            fetch_err_next = 1'b1;
            state_next     = FETCH_HALT;
        end else if (redirect_ok) begin
            pc_next        = redirect_pc;
            out_valid_next = 1'b0;
        end else if (load) begin
            out_instr_next = rom_data;
            out_pc_next    = pc_reg;
            out_valid_next = 1'b1;
            pc_next        = pc_reg + XLEN_P'(4);
        end else if (drain) begin
            out_valid_next = 1'b0;
        end

        // In HALT the output stage must read as empty regardless of history.
        if (state_next == FETCH_HALT) begin
            out_valid_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // PC, output stage, error flag and FSM state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FETCH_RUN;
            pc_reg        <= RESET_PC;
            out_valid_reg <= 1'b0;
            out_instr_reg <= XLEN_P'(NOP_INSTR);
            out_pc_reg    <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            out_valid_reg <= out_valid_next;
            out_instr_reg <= out_instr_next;
            out_pc_reg    <= out_pc_next;
            fetch_err_reg <= fetch_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers.
    // ------------------------------------------------------------------
    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_pc    = out_pc_reg;
    assign fetch_err = fetch_err_reg;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a small ROM image, a spec-level model of the fetch
// stage compared every falling edge, and directed scenarios with literal
// expectations.
module tb_instr_fetch;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              fetch_en;
    logic              redirect_vld;
    logic [XLEN-1:0]   redirect_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic [XLEN-1:0]   rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_instr;
    logic [XLEN-1:0]   out_pc;
    logic              fetch_err;

    logic [XLEN-1:0] rom [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .XLEN_P   (XLEN),
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_en     (fetch_en),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .fetch_err    (fetch_err)
    );

    // ROM sits beside the fetch stage and answers combinationally.
    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: architectural view of the fetch stage. The expected word is
    // looked up in the bench's own ROM by the model's PC, independently of
    // the address the DUT drives.
    // ------------------------------------------------------------------
    logic [31:0] m_pc, m_instr, m_opc;
    logic        m_valid, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 32'h0;
            m_valid <= 1'b0;
            m_instr <= 32'h0000_0013;
            m_opc   <= 32'h0;
            m_err   <= 1'b0;
        end else if (!m_err) begin
            if (redirect_vld && redirect_pc[1:0] != 2'b00) begin
                m_err   <= 1'b1;
                m_valid <= 1'b0;
            end else if (redirect_vld) begin
                m_pc    <= redirect_pc;
                m_valid <= 1'b0;
            end else if (fetch_en && (!m_valid || out_ready)) begin
                m_instr <= rom[(m_pc / 4) % DEPTH];
                m_opc   <= m_pc;
                m_valid <= 1'b1;
                m_pc    <= m_pc + 32'd4;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        chk("mdl_rom_addr", 32'(rom_addr), 32'((m_pc / 4) % DEPTH));
        chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
        chk("mdl_fetch_err", 32'(fetch_err), 32'(m_err));
        if (m_valid) begin
            chk("mdl_out_instr", out_instr, m_instr);
            chk("mdl_out_pc", out_pc, m_opc);
        end
        if (rst_n && out_valid && out_ready)
            $display("XFER pc=%h instr=%h", out_pc, out_instr);
    end

    // Advance one rising edge, then settle past it.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    logic [31:0] exp_words [0:4];

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA000_0000 + 32'(i);
        rom[0] = 32'h0000_0293;
        rom[1] = 32'h0012_8293;
        rom[2] = 32'h0050_2023;
        rom[3] = 32'h0000_2303;
        rom[4] = 32'hFF5F_F0EF;
        for (int i = 0; i < 5; i++) exp_words[i] = rom[i];

        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_vld = 1'b0; redirect_pc = '0;
        step(3);

        // Reset values.
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);

        // Straight-line fetch, one word per cycle.
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("seq_out_pc", out_pc, 32'(i * 4));
            chk("seq_out_instr", out_instr, exp_words[i]);
        end

        // Retarget to 4, then stall three cycles on that word.
        redirect_vld = 1'b1; redirect_pc = 32'h4;
        step(1);
        chk("redir4_bubble", 32'(out_valid), 32'd0);
        redirect_vld = 1'b0;
        step(1);
        chk("redir4_out_pc", out_pc, 32'h4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_out_instr", out_instr, 32'h0012_8293);
            chk("stall_out_pc", out_pc, 32'h4);
            chk("stall_rom_addr", 32'(rom_addr), 32'h2);
        end
        out_ready = 1'b1;
        step(1);
        chk("unstall_out_pc", out_pc, 32'h8);
        step(1);
        chk("pre_redir_out_pc", out_pc, 32'hC);

        // Redirect to 0 while out_pc=C: one bubble, word from 0x10 dropped.
        redirect_vld = 1'b1; redirect_pc = 32'h0;
        step(1);
        chk("redir0_bubble", 32'(out_valid), 32'd0);
        redirect_vld = 1'b0;
        step(1);
        chk("redir0_valid", 32'(out_valid), 32'd1);
        chk("redir0_out_pc", out_pc, 32'h0);
        chk("redir0_out_instr", out_instr, 32'h0000_0293);

        // fetch_en low: current word drains, PC held at 4.
        fetch_en = 1'b0;
        step(1);
        chk("fen0_valid", 32'(out_valid), 32'd0);
        chk("fen0_rom_addr", 32'(rom_addr), 32'h1);
        step(1);
        chk("fen0_hold_addr", 32'(rom_addr), 32'h1);
        fetch_en = 1'b1;
        step(1);
        chk("fen1_out_pc", out_pc, 32'h4);
        chk("fen1_out_instr", out_instr, 32'h0012_8293);

        // ROM address wrap at the top of the image.
        redirect_vld = 1'b1; redirect_pc = 32'h0000_3FFC;
        step(1);
        chk("wrap_rom_addr_top", 32'(rom_addr), 32'hFFF);
        redirect_vld = 1'b0;
        step(1);
        chk("wrap_out_pc_top", out_pc, 32'h3FFC);
        chk("wrap_rom_addr_zero", 32'(rom_addr), 32'h0);
        step(1);
        chk("wrap_out_pc", out_pc, 32'h4000);
        chk("wrap_out_instr", out_instr, 32'h0000_0293);

        // Asynchronous reset in the middle of a stall at out_pc=8.
        redirect_vld = 1'b1; redirect_pc = 32'h8;
        step(1);
        redirect_vld = 1'b0;
        step(1);
        chk("pre_rst_out_pc", out_pc, 32'h8);
        out_ready = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_instr", out_instr, 32'h0000_0013);
        chk("async_rst_err", 32'(fetch_err), 32'd0);
        step(2);
        rst_n = 1'b1; out_ready = 1'b1;
        step(1);
        chk("post_rst_out_pc", out_pc, 32'h0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        // Misaligned redirect halts fetching; nothing but reset recovers.
        redirect_vld = 1'b1; redirect_pc = 32'h6;
        step(1);
        chk("halt_valid", 32'(out_valid), 32'd0);
        chk("halt_err", 32'(fetch_err), 32'd1);
        chk("halt_rom_addr", 32'(rom_addr), 32'h1);
        redirect_pc = 32'h20;
        step(1);
        redirect_vld = 1'b0; fetch_en = 1'b0;
        step(1);
        fetch_en = 1'b1;
        step(2);
        chk("halt_hold_valid", 32'(out_valid), 32'd0);
        chk("halt_hold_addr", 32'(rom_addr), 32'h1);
        chk("halt_hold_err", 32'(fetch_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_err", 32'(fetch_err), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("halt_exit_out_pc", out_pc, 32'h0);
        chk("halt_exit_valid", 32'(out_valid), 32'd1);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch
